bitwise_logic_unit: RTL and testbench

//   Parametrised, pipelined successor to the fixed 16-bit NOT array: per-bit logic

---
 rtl/bitwise_logic_unit_if.sv | 38 +++
 rtl/bitwise_logic_unit.sv | 92 +++++++++
 tb/tb_bitwise_logic_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bitwise_logic_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_logic_unit_if
// Description : Request/result handshake bundle for bitwise_logic_unit.
//               master : producer/consumer side (drives requests, out_ready)
//               slave  : the logic unit (drives in_ready and the result head)
// Ports       : in_valid/in_ready/in_a/in_b/in_op   request channel
//               out_valid/out_ready/out_data/out_zr/out_ng  result channel
//               count                                results buffered
// Revision    : 1.0  initial release
// ============================================================================
interface bitwise_logic_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic [2:0]               in_op;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_zr;
  logic                     out_ng;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zr, out_ng, count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zr, out_ng, count
  );
endinterface
`default_nettype wire

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_logic_unit
// Description : Per-bit logic over WIDTH-bit operands (8 ops) with zero and
//               negative flags, buffered in a DEPTH-entry FIFO behind a
//               valid/ready handshake.
// Ports       : clk    rising-edge clock
//               reset  synchronous, active-high reset
//               bus    bitwise_logic_unit_if.slave (request + result channels)
// Revision    : 1.0  initial release
// ============================================================================
module bitwise_logic_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  bitwise_logic_unit_if.slave  bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem_data [DEPTH];
  logic               r_mem_zr   [DEPTH];
  logic               r_mem_ng   [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic [WIDTH-1:0]   w_result;
  logic               w_full;
  logic               w_nonempty;
  logic               w_accept;
  logic               w_pop;

  always_comb begin
    w_result = '0;
    case (bus.in_op)
      3'b000:  w_result = ~bus.in_a;
      3'b001:  w_result = bus.in_a & bus.in_b;
      3'b010:  w_result = bus.in_a | bus.in_b;
      3'b011:  w_result = bus.in_a ^ bus.in_b;
      3'b100:  w_result = ~(bus.in_a & bus.in_b);
      3'b101:  w_result = ~(bus.in_a | bus.in_b);
      3'b110:  w_result = ~(bus.in_a ^ bus.in_b);
      default: w_result = bus.in_a;
    endcase
  end

  // Handshake qualifiers depend only on registered occupancy, so in_ready
  // never sees out_ready: a pop on a full cycle frees space only next cycle.
  assign w_full     = (r_count == c_full);
  assign w_nonempty = (r_count != '0);
  assign w_accept   = bus.in_valid && !w_full;
  assign w_pop      = bus.out_ready && w_nonempty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: empty-buffer outputs are masked below.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_mem_data[r_wr_ptr] <= w_result;
      r_mem_zr[r_wr_ptr]   <= (w_result == '0);
      r_mem_ng[r_wr_ptr]   <= w_result[WIDTH-1];
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = w_nonempty;
  assign bus.out_data  = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
  assign bus.out_zr    = w_nonempty ? r_mem_zr[r_rd_ptr]   : 1'b0;
  assign bus.out_ng    = w_nonempty ? r_mem_ng[r_rd_ptr]   : 1'b0;
  assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_logic_unit
// Description : Self-checking bench. A 16-bit/2-deep instance takes directed
//               sequences, an 8-bit/4-deep instance takes randomized traffic
//               with stalls on both sides; both are compared every cycle
//               against a truth-table result model and a queue scoreboard.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_bitwise_logic_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16;
  logic rst8;

  bitwise_logic_unit_if #(.WIDTH(16), .DEPTH(2)) bus16 ();
  bitwise_logic_unit_if #(.WIDTH(8),  .DEPTH(4)) bus8 ();

  bitwise_logic_unit #(.WIDTH(16), .DEPTH(2)) dut16 (.clk(clk), .reset(rst16), .bus(bus16));
  bitwise_logic_unit #(.WIDTH(8),  .DEPTH(4)) dut8  (.clk(clk), .reset(rst8),  .bus(bus8));

  // Truth table per op, bit index = {a_bit, b_bit}.
  localparam logic [3:0] TT [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                                    4'b0111, 4'b0001, 4'b1001, 4'b1100};

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;   // 0: 16-bit instance, 1: 8-bit instance
  int mw       = 16;
  int md       = 2;
  logic [17:0] q[$];  // {ng, zr, data}

  function automatic logic [15:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op, input int w);
    logic [15:0] r;
    logic [3:0]  t;
    r = '0;
    t = TT[op];
    for (int i = 0; i < w; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: at the falling edge compare outputs with the model, drive the
  // next inputs, then advance the model for the coming rising edge.
  task automatic step(input logic rst, input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] op, input logic ordy,
                      output logic acc);
    logic        ov, ir, zr, ng, pop;
    logic [15:0] od, r;
    logic [31:0] cnt;
    logic [17:0] head;
    @(negedge clk);
    if (sel == 0) begin
      ov = bus16.out_valid; ir = bus16.in_ready; zr = bus16.out_zr; ng = bus16.out_ng;
      od = bus16.out_data;  cnt = 32'(bus16.count);
    end else begin
      ov = bus8.out_valid; ir = bus8.in_ready; zr = bus8.out_zr; ng = bus8.out_ng;
      od = {8'h00, bus8.out_data}; cnt = 32'(bus8.count);
    end
    head = (q.size() > 0) ? q[0] : 18'h0;
    check("out_valid", 32'(ov), 32'(q.size() > 0));
    check("in_ready",  32'(ir), 32'(q.size() < md));
    check("count",     cnt,     32'(q.size()));
    check("out_data",  32'(od), 32'(head[15:0]));
    check("out_zr",    32'(zr), 32'(head[16]));
    check("out_ng",    32'(ng), 32'(head[17]));

    if (sel == 0) begin
      rst16 = rst; bus16.in_valid = v; bus16.in_a = a; bus16.in_b = b;
      bus16.in_op = op; bus16.out_ready = ordy;
    end else begin
      rst8 = rst; bus8.in_valid = v; bus8.in_a = a[7:0]; bus8.in_b = b[7:0];
      bus8.in_op = op; bus8.out_ready = ordy;
    end

    acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      pop = ordy && (q.size() > 0);
      acc = v && (q.size() < md);
      if (pop) void'(q.pop_front());
      if (acc) begin
        r = golden(a, b, op, mw);
        q.push_back({r[mw-1], (r == 16'h0), r});
      end
    end
  endtask

  localparam logic [15:0] SWEEP [8] = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0,
                                        16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};

  initial begin
    logic        acc, pend, ordy;
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    int          k, acc_n, pop_n;

    rst16 = 1'b1; rst8 = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_op = '0; bus16.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.in_a  = '0; bus8.in_b  = '0; bus8.in_op  = '0; bus8.out_ready  = 1'b0;
    repeat (2) @(posedge clk);

    // NOT of 00FF, first-cycle latency and flags
    step(0, 1, 16'h00FF, 16'h0000, 3'b000, 0, acc);
    @(posedge clk); #1;
    check("t1_valid", 32'(bus16.out_valid), 32'd1);
    check("t1_data",  32'(bus16.out_data),  32'h0000FF00);
    check("t1_ng",    32'(bus16.out_ng),    32'd1);
    check("t1_zr",    32'(bus16.out_zr),    32'd0);
    check("t1_count", 32'(bus16.count),     32'd1);
    step(0, 0, 16'h0, 16'h0, 3'b000, 1, acc);

    // Sweep all ops, streaming one result per cycle
    for (int op = 0; op < 8; op++) begin
      step(0, 1, 16'hF0F0, 16'hFF00, 3'(op), 1, acc);
      @(posedge clk); #1;
      check("t2_sweep", 32'(bus16.out_data), 32'(SWEEP[op]));
    end
    step(0, 1, 16'h0000, 16'h1234, 3'b001, 1, acc);
    @(posedge clk); #1;
    check("t2_zr", 32'(bus16.out_zr), 32'd1);
    step(0, 0, 16'h0, 16'h0, 3'b000, 1, acc);

    // Back-pressure: two accepted, third held while full
    step(0, 1, 16'h1111, 16'h0, 3'b111, 0, acc);
    step(0, 1, 16'h2222, 16'h0, 3'b111, 0, acc);
    @(posedge clk); #1;
    check("t3_in_ready", 32'(bus16.in_ready), 32'd0);
    check("t3_count",    32'(bus16.count),    32'd2);
    step(0, 1, 16'h3333, 16'h0, 3'b111, 0, acc);
    check("t3_held", 32'(acc), 32'd0);
    k = 0;
    acc = 1'b0;
    while (!acc && k < 5) begin
      k++;
      step(0, 1, 16'h3333, 16'h0, 3'b111, 1, acc);
    end
    check("t4_accept_cycle", 32'(k), 32'd2);
    for (int i = 0; i < 6; i++) step(0, 1, 16'($urandom), 16'($urandom), 3'($urandom), 1, acc);
    @(posedge clk); #1;
    check("t4_stream_count", 32'(bus16.count), 32'd1);

    // Reset while full with a request presented
    step(0, 0, 16'h0, 16'h0, 3'b000, 0, acc);
    step(0, 1, 16'hABCD, 16'h0, 3'b111, 0, acc);
    step(1, 1, 16'h5555, 16'h0, 3'b111, 1, acc);
    @(posedge clk); #1;
    check("t5_valid",    32'(bus16.out_valid), 32'd0);
    check("t5_count",    32'(bus16.count),     32'd0);
    check("t5_data",     32'(bus16.out_data),  32'd0);
    check("t5_in_ready", 32'(bus16.in_ready),  32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 16'h0, 3'b000, 1, acc);

    // Randomized traffic on the 8-bit, 4-deep instance
    sel = 1; mw = 8; md = 4;
    q.delete();
    pend = 1'b0; acc_n = 0; pop_n = 0;
    ra = '0; rb = '0; rop = '0;
    for (int cyc = 0; cyc < 3000 && acc_n < 100; cyc++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; ra = 16'($urandom); rb = 16'($urandom); rop = 3'($urandom);
      end
      ordy = ($urandom_range(0, 2) != 0);
      if (ordy && q.size() > 0) pop_n++;
      step(0, pend, ra, rb, rop, ordy, acc);
      if (acc) begin acc_n++; pend = 1'b0; end
    end
    check("rand_accepted", 32'(acc_n), 32'd100);
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      pop_n++;
      step(0, 0, 16'h0, 16'h0, 3'b000, 1, acc);
    end
    step(0, 0, 16'h0, 16'h0, 3'b000, 1, acc);
    check("rand_popped", 32'(pop_n), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
